// File: rtl/down_counter_ld_if.sv
// Control/status bundle for the loadable down-counter: the sequencer side drives
// load/count requests, the counter side returns the count and its status flags.
interface down_counter_ld_if #(
    parameter int W = 3
);
    logic         LD;
    logic [W-1:0] DIN;
    logic         CNT;
    logic         RELOAD;
    logic [W-1:0] OUT;
    logic         ZERO;
    logic         BUSY;
    logic         DONE;
    logic         BORROW;

    modport master (
        output LD, DIN, CNT, RELOAD,
        input  OUT, ZERO, BUSY, DONE, BORROW
    );

    modport slave (
        input  LD, DIN, CNT, RELOAD,
        output OUT, ZERO, BUSY, DONE, BORROW
    );
endinterface

// File: rtl/down_counter_ld.sv
// Loadable down-counter with IDLE/RUN control: counts an iteration budget down to
// zero, pulses DONE on completion, optionally reloads for back-to-back operations.
module down_counter_ld #(
    parameter int W = 3
) (
    input  logic               CLK,
    input  logic               RST,
    down_counter_ld_if.slave   bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [W-1:0] ONE = W'(1);

    state_t       state_reg, state_next;
    logic [W-1:0] out_reg, out_next;
    logic [W-1:0] reload_reg, reload_next;
    logic         done_reg, done_next;
    logic         borrow_reg, borrow_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            out_reg    <= '0;
            reload_reg <= '0;
            done_reg   <= 1'b0;
            borrow_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            out_reg    <= out_next;
            reload_reg <= reload_next;
            done_reg   <= done_next;
            borrow_reg <= borrow_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        out_next    = out_reg;
        reload_next = reload_reg;
        done_next   = 1'b0;
        borrow_next = 1'b0;

        if (bus.LD) begin
            // A zero-length operation completes on the load edge itself.
            out_next    = bus.DIN;
            reload_next = bus.DIN;
            if (bus.DIN != '0) begin
                state_next = RUN;
            end else begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
        end else if (bus.CNT) begin
            case (state_reg)
                RUN: begin
                    if (out_reg > ONE) begin
                        out_next = out_reg - ONE;
                    end else begin
                        done_next = 1'b1;
                        if (bus.RELOAD) begin
                            out_next = reload_reg;
                        end else begin
                            out_next   = '0;
                            state_next = IDLE;
                        end
                    end
                end
                default: begin
                    // Counting while idle never wraps; it is only flagged.
                    borrow_next = 1'b1;
                end
            endcase
        end
    end

    assign bus.OUT    = out_reg;
    assign bus.ZERO   = (out_reg == '0);
    assign bus.BUSY   = (state_reg == RUN);
    assign bus.DONE   = done_reg;
    assign bus.BORROW = borrow_reg;
endmodule

// File: tb/tb_down_counter_ld.sv
// Self-checking bench for down_counter_ld: directed scenarios followed by random
// traffic, all compared against a behavioural model of the counter's rules.
module tb_down_counter_ld;
    localparam int W = 3;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   step_no = 0;

    down_counter_ld_if #(.W(W)) bus ();

    down_counter_ld #(.W(W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: remaining iterations, remembered budget, activity flag.
    int m_out    = 0;
    int m_reload = 0;
    bit m_busy   = 1'b0;
    bit m_done   = 1'b0;
    bit m_borrow = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s step=%0d got=%0d expected=%0d", tag, step_no, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit ld, input int d, input bit c, input bit rl);
        m_done   = 1'b0;
        m_borrow = 1'b0;
        if (r) begin
            m_out = 0; m_reload = 0; m_busy = 1'b0;
        end else if (ld) begin
            m_out = d; m_reload = d;
            m_busy = (d != 0);
            m_done = (d == 0);
        end else if (c && !m_busy) begin
            m_borrow = 1'b1;
        end else if (c) begin
            m_out = m_out - 1;
            if (m_out == 0) begin
                m_done = 1'b1;
                if (rl) m_out = m_reload;
                else    m_busy = 1'b0;
            end
        end
    endtask

    task automatic step(input bit r, input bit ld, input int d, input bit c, input bit rl);
        @(negedge clk);
        rst = r; bus.LD = ld; bus.DIN = W'(d); bus.CNT = c; bus.RELOAD = rl;
        @(posedge clk);
        model_edge(r, ld, d, c, rl);
        #1;
        step_no++;
        chk("OUT", int'(bus.OUT), m_out);
        chk("ZERO", int'(bus.ZERO), int'(m_out == 0));
        chk("BUSY", int'(bus.BUSY), int'(m_busy));
        chk("DONE", int'(bus.DONE), int'(m_done));
        chk("BORROW", int'(bus.BORROW), int'(m_borrow));
        $display("step %0d rst=%0b ld=%0b din=%0d cnt=%0b reload=%0b -> out=%0d zero=%0b busy=%0b done=%0b borrow=%0b",
                 step_no, r, ld, d, c, rl, bus.OUT, bus.ZERO, bus.BUSY, bus.DONE, bus.BORROW);
    endtask

    initial begin
        rst = 1'b0; bus.LD = 1'b0; bus.DIN = '0; bus.CNT = 1'b0; bus.RELOAD = 1'b0;

        // Reset, then counting while idle only raises BORROW.
        step(1, 0, 0, 0, 0);
        chk("RST_OUT", int'(bus.OUT), 0);
        chk("RST_ZERO", int'(bus.ZERO), 1);
        step(0, 0, 0, 1, 0);
        chk("IDLE_BORROW", int'(bus.BORROW), 1);
        step(0, 0, 0, 1, 0);

        // Basic countdown 5..0 with a single DONE as OUT reaches 0.
        step(0, 1, 5, 0, 0);
        for (int i = 4; i >= 0; i--) begin
            step(0, 0, 0, 1, 0);
            chk("CD_OUT", int'(bus.OUT), i);
            chk("CD_DONE", int'(bus.DONE), int'(i == 0));
        end
        step(0, 0, 0, 0, 0);

        // Stall pattern 1,0,0,1,1 from 3.
        step(0, 1, 3, 0, 0);
        step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("STALL_OUT", int'(bus.OUT), 1);
        step(0, 0, 0, 1, 0);
        chk("STALL_DONE", int'(bus.DONE), 1);

        // Auto-reload from 2: OUT 1,2,1,2,1,2 with BUSY held.
        step(0, 1, 2, 0, 1);
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, 0, 1, 1);
            chk("AR_OUT", int'(bus.OUT), (i % 2 == 1) ? 1 : 2);
            chk("AR_BUSY", int'(bus.BUSY), 1);
        end

        // Load edge cases.
        step(0, 1, 0, 0, 0);
        chk("LD0_DONE", int'(bus.DONE), 1);
        step(0, 1, MAXV, 1, 0);
        chk("LDCNT_OUT", int'(bus.OUT), MAXV);
        step(0, 1, 5, 0, 0); step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0);
        step(0, 1, 6, 1, 0);
        chk("RELD_OUT", int'(bus.OUT), 6);

        // Reset mid-operation overrides a simultaneous load and count.
        step(0, 1, 7, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        chk("MID_OUT", int'(bus.OUT), 4);
        step(1, 1, 7, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("POSTRST_BORROW", int'(bus.BORROW), 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, MAXV)),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/down_counter_ld.md
Name: down_counter_ld

Overview:
- Loadable down-counter with a small control FSM. It is the count-down counterpart of the 3-bit up-counter (CNT/CLK/RST/OUT).
- The ALU sequencer loads an iteration count for multi-cycle operations (shift-add multiply, restoring divide). The counter then decrements once per enabled step and flags completion with a one-cycle DONE pulse.
- Optional auto-reload mode supports back-to-back operations of equal length.

Parameters:
- W, 3, counter width in bits. Legal range 2..16.

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  reset, synchronous, active-high
- LD  input  1  load strobe: capture DIN into OUT and into the reload register
- DIN  input  W  load value (iteration count)
- CNT  input  1  count enable: decrement one step
- RELOAD  input  1  auto-reload mode select, sampled when the count reaches 0
- OUT  output  W  current count, registered
- ZERO  output  1  combinational, equals (OUT == 0)
- BUSY  output  1  registered; 1 while FSM is in RUN
- DONE  output  1  registered one-cycle pulse; count reached 0
- BORROW  output  1  registered one-cycle pulse; CNT asserted while IDLE (underflow attempt)

Behaviour:
- Reset: RST=1 at a rising edge has the following effect:
  - OUT=0 and the reload register = 0.
  - FSM goes to IDLE.
  - BUSY=0, DONE=0, BORROW=0, and ZERO=1 as a consequence.
  - RST overrides LD and CNT.
  - RST during RUN aborts the count; no DONE is produced.
- States: IDLE and RUN (2-bit or 1-bit encoding is implementer's choice). BUSY = (state == RUN), registered with the state.
- DONE and BORROW default to 0 every cycle unless a rule below sets them.
- Priority per edge: RST > LD > CNT.
- LD=1 (any state):
  - OUT<=DIN and reload register <= DIN.
  - If DIN != 0: next state RUN.
  - If DIN == 0: next state IDLE and DONE<=1 (a zero-iteration op completes immediately).
  - CNT is ignored in that cycle.
  - LD during RUN restarts the count; the aborted count produces no DONE.
- RUN, CNT=0: hold all state.
- RUN, CNT=1, OUT > 1: OUT<=OUT-1; stay in RUN.
- RUN, CNT=1, OUT == 1 (terminal step): DONE<=1, then:
  - RELOAD=0: OUT<=0, next state IDLE.
  - RELOAD=1: OUT<=reload register, stay in RUN, BUSY stays 1.
- IDLE, CNT=1, LD=0: OUT holds (no wrap-around, ever) and BORROW<=1.
- IDLE, CNT=0: hold.
- Latency: DONE is asserted in the cycle after the edge that takes OUT to 0 (or reloads it). With OUT loaded to N and CNT held at 1, DONE goes high N edges after the load edge.
- Arithmetic: unsigned W-bit. OUT never underflows. The maximum load is 2^W-1.
- X-safety: OUT, BUSY, DONE and BORROW are all defined from the first reset edge onward.

Test Plan:
- Reset then idle count: RST=1 for 1 edge, then CNT=1 for 2 edges -> OUT=0, ZERO=1, BUSY=0, BORROW=1 on each of those edges, DONE=0 throughout.
- Basic countdown (W=3): LD=1, DIN=5, then CNT=1 continuously, RELOAD=0 -> OUT sequence 5,4,3,2,1,0. DONE=1 for exactly one cycle when OUT becomes 0. BUSY falls in the same cycle.
- Stall: load 3, then apply CNT pattern 1,0,0,1,1 -> OUT sequence 3,2,2,2,1,0. DONE=1 only after the final step.
- Auto-reload: load 2, RELOAD=1, CNT=1 for 6 edges -> OUT sequence 2,1,2,1,2,1,2. DONE pulses after edges 2, 4 and 6. BUSY stays 1.
- Load edge cases:
  - LD with DIN=0 -> OUT=0, DONE=1 for one cycle, BUSY=0.
  - LD=1 and CNT=1 in the same cycle with DIN=7 -> OUT=7 (no decrement).
  - LD with DIN=6 mid-count at OUT=3 -> OUT=6, no DONE.
- Reset mid-operation: load 7, count 3 steps (OUT=4), then RST=1 together with LD=1 and CNT=1 -> OUT=0, BUSY=0, DONE=0. The following CNT=1 gives BORROW=1.
